// File: rtl/audio_mixer_pkg.sv
// audio_pkg: shared types and constants for the audio_mixer slice.
//   mix_state_e - mix-pass FSM states (IDLE, ACC, LOAD)
//   VOL_BITS    - width of each per-channel volume field
//   mix_width() - accumulator/DAC width that cannot overflow for
//                 `channels` full-scale unsigned samples of `dw` bits
package audio_pkg;

  localparam int unsigned VOL_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    LOAD
  } mix_state_e;

  function automatic int unsigned mix_width(input int unsigned channels,
                                            input int unsigned dw);
    return dw + $clog2(channels) + 1;
  endfunction

endpackage

// File: rtl/audio_mixer_if.sv
// audio_mixer_if: sample/control bundle between the sound generators and
// the mixer.
//   tick    - sample strobe, starts a mix pass
//   ch      - channel samples, channel i at [i*DW +: DW]
//   pan     - bit 2i routes channel i left, bit 2i+1 routes it right
//   vol     - per-channel 4-bit volume (only used with MIXER_VOLUME_EN)
//   busy    - mix pass in progress
//   valid   - one-cycle pulse when new sums reach the DACs
//   overrun - one-cycle pulse when tick arrives while busy
//   audio   - bit 0 left bitstream, bit 1 right bitstream
// master: sample source side; slave: the mixer.
interface audio_mixer_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DW       = 8
);
  import audio_pkg::*;

  logic                         tick;
  logic [CHANNELS*DW-1:0]       ch;
  logic [2*CHANNELS-1:0]        pan;
  logic [VOL_BITS*CHANNELS-1:0] vol;
  logic                         busy;
  logic                         valid;
  logic                         overrun;
  logic [1:0]                   audio;

  modport master (
    output tick, ch, pan, vol,
    input  busy, valid, overrun, audio
  );

  modport slave (
    input  tick, ch, pan, vol,
    output busy, valid, overrun, audio
  );

endinterface

// File: rtl/audio_mixer_sd_dac.sv
// sd_dac: first-order sigma-delta DAC producing a 1-bit stream.
//   clock - system clock
//   reset - asynchronous active-high reset
//   d     - W-bit unsigned level, ones density of q is d/2^W
//   q     - bitstream (carry out of the accumulator)
module sd_dac #(
  parameter int unsigned W = 11
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic         q
);

  logic [W:0] sd_q;
  logic [W:0] sd_d;

  // The carry from the previous step is dropped before adding again.
  always_comb begin
    sd_d = {1'b0, sd_q[W-1:0]} + {1'b0, d};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sd_q <= '0;
    end else begin
      sd_q <= sd_d;
    end
  end

  assign q = sd_q[W];

endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: N-channel stereo mixer with per-channel pan feeding one
// sigma-delta DAC per side. A tick snapshots all inputs, the channels are
// then accumulated one per clock, and the sums are loaded into the DACs.
//   clock - system clock
//   reset - asynchronous active-high reset
//   bus   - audio_mixer_if slave (tick/ch/pan/vol in; busy/valid/overrun/audio out)
// Optional: define MIXER_VOLUME_EN to scale each channel by (vol+1)/16 with
// vol=0 muting; otherwise vol is ignored.
module audio_mixer
  import audio_pkg::*;
#(
  parameter int unsigned  CHANNELS = 3,
  parameter int unsigned  DW       = 8,
  localparam int unsigned MW       = mix_width(CHANNELS, DW)
) (
  input  logic          clock,
  input  logic          reset,
  audio_mixer_if.slave  bus
);

  localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  mix_state_e             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [MW-1:0]          acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [MW-1:0]          dac_l_q, dac_l_d, dac_r_q, dac_r_d;
  logic [CHANNELS*DW-1:0] ch_q;
  logic [2*CHANNELS-1:0]  pan_q;
  logic                   snap;
  logic                   busy;
  logic                   valid;

  logic [DW-1:0]          ch_sel;
  logic                   pan_l_sel;
  logic                   pan_r_sel;
  logic [MW-1:0]          term;

`ifdef MIXER_VOLUME_EN
  logic [VOL_BITS*CHANNELS-1:0] vol_q;
  logic [VOL_BITS-1:0]          vol_sel;
  logic [DW+VOL_BITS-1:0]       prod;
`endif

  // Channel selection by idx from the shadow copies.
  always_comb begin
    ch_sel    = '0;
    pan_l_sel = 1'b0;
    pan_r_sel = 1'b0;
`ifdef MIXER_VOLUME_EN
    vol_sel   = '0;
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (idx_q == IW'(i)) begin
        ch_sel    = ch_q[i*DW +: DW];
        pan_l_sel = pan_q[2*i];
        pan_r_sel = pan_q[2*i+1];
`ifdef MIXER_VOLUME_EN
        vol_sel   = vol_q[i*VOL_BITS +: VOL_BITS];
`endif
      end
    end
  end

`ifdef MIXER_VOLUME_EN
  // One shared multiplier; ch*(vol+1) <= (2^DW-1)*16 fits in DW+4 bits.
  always_comb begin
    prod = (DW+VOL_BITS)'(ch_sel) * (DW+VOL_BITS)'({1'b0, vol_sel} + 5'd1);
    term = (vol_sel == '0) ? '0 : MW'(prod >> VOL_BITS);
  end
`else
  always_comb begin
    term = MW'(ch_sel);
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    dac_l_d = dac_l_q;
    dac_r_d = dac_r_q;
    snap    = 1'b0;
    busy    = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tick) begin
          snap    = 1'b1;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        busy = 1'b1;
        if (pan_l_sel) acc_l_d = acc_l_q + term;
        if (pan_r_sel) acc_r_d = acc_r_q + term;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(CHANNELS - 1)) state_d = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        valid   = 1'b1;
        dac_l_d = acc_l_q;
        dac_r_d = acc_r_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      dac_l_q <= '0;
      dac_r_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      dac_l_q <= dac_l_d;
      dac_r_q <= dac_r_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_q  <= '0;
      pan_q <= '0;
`ifdef MIXER_VOLUME_EN
      vol_q <= '0;
`endif
    end else if (snap) begin
      ch_q  <= bus.ch;
      pan_q <= bus.pan;
`ifdef MIXER_VOLUME_EN
      vol_q <= bus.vol;
`endif
    end
  end

  sd_dac #(.W(MW)) u_dac_l (
    .clock (clock),
    .reset (reset),
    .d     (dac_l_q),
    .q     (bus.audio[0])
  );

  sd_dac #(.W(MW)) u_dac_r (
    .clock (clock),
    .reset (reset),
    .d     (dac_r_q),
    .q     (bus.audio[1])
  );

  assign bus.busy    = busy;
  assign bus.valid   = valid;
  assign bus.overrun = busy & bus.tick;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer (CHANNELS=3, DW=8, so MW=11 and a DAC
// emits dacIn ones per 2048 clocks).
module tb_audio_mixer;
  import audio_pkg::*;

  localparam int unsigned CHANNELS = 3;
  localparam int unsigned DW       = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  audio_mixer_if #(.CHANNELS(CHANNELS), .DW(DW)) bus ();

  audio_mixer #(.CHANNELS(CHANNELS), .DW(DW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_ovr   = 0;
  int ones_l  = 0;
  int ones_r  = 0;
  int lat;

  // Counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.valid === 1'b1)    n_valid++;
    if (bus.overrun === 1'b1)  n_ovr++;
    if (bus.audio[0] === 1'b1) ones_l++;
    if (bus.audio[1] === 1'b1) ones_r++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    total++;
    assert ((obs >= exp - 1) && (obs <= exp + 1)) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d+-1", tag, obs, exp);
    end
  endtask

  // One tick, then watch 12 cycles; lat = cycle index of first valid (T=0).
  task automatic run_pass(output int l);
    @(posedge clk); #1;
    bus.tick = 1'b1;
    n_valid = 0;
    n_ovr   = 0;
    l = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.valid === 1'b1 && l < 0) l = k;
      @(posedge clk); #1;
      bus.tick = 1'b0;
    end
  endtask

  task automatic measure(input string tag, input int el, input int er);
    @(posedge clk); #1;
    ones_l = 0;
    ones_r = 0;
    repeat (2048) @(posedge clk);
    #1;
    chk_near({tag, "_dens_L"}, ones_l, el);
    chk_near({tag, "_dens_R"}, ones_r, er);
  endtask

  task automatic idle_silent(input string tag);
    @(posedge clk); #1;
    ones_l = 0;
    ones_r = 0;
    repeat (64) @(posedge clk);
    #1;
    chk({tag, "_ones_L"}, ones_l, 0);
    chk({tag, "_ones_R"}, ones_r, 0);
  endtask

  initial begin
    rst      = 1'b1;
    bus.tick = 1'b0;
    bus.ch   = '0;
    bus.pan  = '0;
    bus.vol  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    int'(bus.busy),    0);
    chk("rst_valid",   int'(bus.valid),   0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_audio",   int'(bus.audio),   0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_silent("idle");

    // Full scale on all channels, both sides: 3*255 = 765.
    bus.ch  = 24'hFFFFFF;
    bus.pan = 6'b111111;
    bus.vol = 12'hFFF;
    run_pass(lat);
    chk("ff_latency", lat, 4);
    chk("ff_nvalid", n_valid, 1);
    measure("ff", 765, 765);

    // Reset while the DACs are toggling.
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst2_audio", int'(bus.audio), 0);
    chk("rst2_busy",  int'(bus.busy),  0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_silent("rst2_idle");

    // ch0=0x80 both, ch1=0x40 left, ch2=0x20 right.
    bus.ch  = 24'h204080;
    bus.pan = 6'b10_01_11;
    run_pass(lat);
    chk("pan_nvalid", n_valid, 1);
    measure("pan", 192, 160);

    // Second tick at T+2 (in ACC) with changed ch must not disturb the pass.
    bus.ch  = 24'h302010;
    bus.pan = 6'b111111;
    @(posedge clk); #1;
    bus.tick = 1'b1;
    n_valid = 0;
    n_ovr   = 0;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    bus.ch   = 24'hFFFFFF;
    @(posedge clk); #1;
    bus.tick = 1'b1;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_acc_count",  n_ovr,   1);
    chk("ovr_acc_nvalid", n_valid, 1);
    measure("ovr_acc", 96, 96);

    // Tick coinciding with LOAD (T+4) is also an overrun and is dropped.
    bus.ch = 24'h010101;
    @(posedge clk); #1;
    bus.tick = 1'b1;
    n_valid = 0;
    n_ovr   = 0;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.ch = 24'h808080;
    @(posedge clk); #1;
    bus.tick = 1'b1;
    @(negedge clk);
    chk("ovr_load_valid", int'(bus.valid), 1);
    @(posedge clk); #1;
    bus.tick = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_load_count",  n_ovr,   1);
    chk("ovr_load_nvalid", n_valid, 1);
    measure("ovr_load", 3, 3);

    // Reset during ACC at T+2 aborts the pass.
    bus.ch = 24'hFFFFFF;
    @(posedge clk); #1;
    bus.tick = 1'b1;
    n_valid = 0;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_nvalid", n_valid, 0);
    idle_silent("abort_idle");
    bus.ch = 24'h204080;
    run_pass(lat);
    chk("after_abort_latency", lat, 4);
    chk("after_abort_nvalid", n_valid, 1);
    measure("after_abort", 224, 224);

    // Volume: ch0 = 0xFF routed left only.
    bus.ch  = 24'h0000FF;
    bus.pan = 6'b000001;
`ifdef MIXER_VOLUME_EN
    bus.vol = 12'h00F;
    run_pass(lat);
    measure("vol15", 255, 0);
    bus.vol = 12'h007;
    run_pass(lat);
    measure("vol7", 127, 0);
    bus.vol = 12'h000;
    run_pass(lat);
    measure("vol0", 0, 0);
`else
    bus.vol = 12'h000;
    run_pass(lat);
    measure("novol", 255, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
